// File: rtl/cp_link_pkg.sv
// Shared constants and helpers for the coprocessor link interface and its FIFOs.
package cp_link_pkg;

    localparam int WORD_W        = 16;
    localparam int CP_FIFO_DEPTH = 8;

    // Occupancy counters need one extra bit so that a completely full FIFO (DEPTH) is representable.
    function automatic int cp_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/cp_sync_fifo.sv
// Single-clock show-ahead FIFO: the head word is visible on o_data whenever the FIFO is non-empty.
module cp_sync_fifo
    import cp_link_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = CP_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [cp_cnt_w(DEPTH)-1:0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = cp_cnt_w(DEPTH);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_push_en;
    logic             w_pop_en;

    assign o_empty   = (r_count == CW'(0));
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_push_en = i_push & ~o_full;
    assign w_pop_en  = i_pop & ~o_empty;
    // Forcing zero when empty keeps the head output clean during and right after reset.
    assign o_data    = o_empty ? {WIDTH{1'b0}} : r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage write port; contents need no reset because reads are masked while empty.
    always_ff @(posedge clk) begin
        if (w_push_en) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cp_link_interface.sv
// GPP <-> interconnect link: TX and RX show-ahead FIFOs with valid/ready glue and sticky error flags.
module cp_link_interface
    import cp_link_pkg::*;
#(
    parameter int WIDTH = WORD_W,
    parameter int DEPTH = CP_FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           gpp_tx_data,
    input  logic                       gpp_trf_cp,
    output logic                       tx_full,
    output logic [cp_cnt_w(DEPTH)-1:0] tx_count,
    output logic                       link_tx_valid,
    output logic [WIDTH-1:0]           link_tx_data,
    input  logic                       link_tx_ready,
    input  logic                       link_rx_valid,
    input  logic [WIDTH-1:0]           link_rx_data,
    output logic                       link_rx_ready,
    input  logic                       gpp_rtr_cp,
    output logic [WIDTH-1:0]           RAM_rx_data_out,
    output logic                       data_rx_flag,
    output logic [cp_cnt_w(DEPTH)-1:0] rx_count,
    input  logic                       err_clr,
    output logic                       tx_overflow,
    output logic                       rx_underflow
);

    logic r_ready_en;
    logic r_tx_overflow;
    logic r_rx_underflow;
    logic w_tx_overflow_nxt;
    logic w_rx_underflow_nxt;
    logic w_tx_full;
    logic w_tx_empty;
    logic w_rx_full;
    logic w_rx_empty;
    logic w_tx_pop;
    logic w_rx_push;

    assign tx_full       = w_tx_full;
    assign link_tx_valid = ~w_tx_empty;
    assign data_rx_flag  = ~w_rx_empty;
    // RX stays closed while in reset and opens on the first clock edge after release.
    assign link_rx_ready = r_ready_en & ~w_rx_full;
    assign w_tx_pop      = link_tx_valid & link_tx_ready;
    assign w_rx_push     = link_rx_valid & link_rx_ready;
    assign tx_overflow   = r_tx_overflow;
    assign rx_underflow  = r_rx_underflow;

    cp_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (gpp_trf_cp),
        .i_data  (gpp_tx_data),
        .i_pop   (w_tx_pop),
        .o_data  (link_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty),
        .o_count (tx_count)
    );

    cp_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push),
        .i_data  (link_rx_data),
        .i_pop   (gpp_rtr_cp),
        .o_data  (RAM_rx_data_out),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty),
        .o_count (rx_count)
    );

    // Sticky error next-state: a new error outranks a same-cycle clear.
    always_comb begin
        w_tx_overflow_nxt  = r_tx_overflow;
        w_rx_underflow_nxt = r_rx_underflow;
        if (gpp_trf_cp && w_tx_full) begin
            w_tx_overflow_nxt = 1'b1;
        end else if (err_clr) begin
            w_tx_overflow_nxt = 1'b0;
        end else begin
            w_tx_overflow_nxt = r_tx_overflow;
        end
        if (gpp_rtr_cp && w_rx_empty) begin
            w_rx_underflow_nxt = 1'b1;
        end else if (err_clr) begin
            w_rx_underflow_nxt = 1'b0;
        end else begin
            w_rx_underflow_nxt = r_rx_underflow;
        end
    end

    // Error flag and RX-enable registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready_en     <= 1'b0;
            r_tx_overflow  <= 1'b0;
            r_rx_underflow <= 1'b0;
        end else begin
            r_ready_en     <= 1'b1;
            r_tx_overflow  <= w_tx_overflow_nxt;
            r_rx_underflow <= w_rx_underflow_nxt;
        end
    end

endmodule

// File: tb/tb_cp_link_interface.sv
// Directed self-checking bench for cp_link_interface (WIDTH=16, DEPTH=8).
module tb_cp_link_interface;

    logic        clk;
    logic        rst;
    logic [15:0] gpp_tx_data;
    logic        gpp_trf_cp;
    logic        tx_full;
    logic [3:0]  tx_count;
    logic        link_tx_valid;
    logic [15:0] link_tx_data;
    logic        link_tx_ready;
    logic        link_rx_valid;
    logic [15:0] link_rx_data;
    logic        link_rx_ready;
    logic        gpp_rtr_cp;
    logic [15:0] RAM_rx_data_out;
    logic        data_rx_flag;
    logic [3:0]  rx_count;
    logic        err_clr;
    logic        tx_overflow;
    logic        rx_underflow;

    int total;
    int bad;

    cp_link_interface #(.WIDTH(16), .DEPTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .gpp_tx_data     (gpp_tx_data),
        .gpp_trf_cp      (gpp_trf_cp),
        .tx_full         (tx_full),
        .tx_count        (tx_count),
        .link_tx_valid   (link_tx_valid),
        .link_tx_data    (link_tx_data),
        .link_tx_ready   (link_tx_ready),
        .link_rx_valid   (link_rx_valid),
        .link_rx_data    (link_rx_data),
        .link_rx_ready   (link_rx_ready),
        .gpp_rtr_cp      (gpp_rtr_cp),
        .RAM_rx_data_out (RAM_rx_data_out),
        .data_rx_flag    (data_rx_flag),
        .rx_count        (rx_count),
        .err_clr         (err_clr),
        .tx_overflow     (tx_overflow),
        .rx_underflow    (rx_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        gpp_tx_data = 16'h0000;
        gpp_trf_cp = 1'b0;
        link_tx_ready = 1'b0;
        link_rx_valid = 1'b0;
        link_rx_data = 16'h0000;
        gpp_rtr_cp = 1'b0;
        err_clr = 1'b0;

        // Reset state
        #3;
        chk("rst_tx_valid", 32'(link_tx_valid), 32'd0);
        chk("rst_rx_flag",  32'(data_rx_flag),  32'd0);
        chk("rst_tx_full",  32'(tx_full),       32'd0);
        chk("rst_rx_ready", 32'(link_rx_ready), 32'd0);
        chk("rst_tx_data",  32'(link_tx_data),  32'd0);
        chk("rst_rx_data",  32'(RAM_rx_data_out), 32'd0);
        chk("rst_counts",   32'({tx_count, rx_count}), 32'd0);
        chk("rst_errs",     32'({tx_overflow, rx_underflow}), 32'd0);
        #6;
        rst = 1'b1;
        tick();
        chk("post_rst_rx_ready", 32'(link_rx_ready), 32'd1);

        // Streaming TX: one word per cycle, head visible the cycle after the push
        link_tx_ready = 1'b1;
        gpp_trf_cp = 1'b1;
        gpp_tx_data = 16'hA001;
        tick();
        chk("stream_valid0", 32'(link_tx_valid), 32'd1);
        chk("stream_data0",  32'(link_tx_data),  32'hA001);
        gpp_tx_data = 16'hA002;
        tick();
        chk("stream_data1",  32'(link_tx_data),  32'hA002);
        chk("stream_cnt1",   32'(tx_count),      32'd1);
        gpp_tx_data = 16'hA003;
        tick();
        chk("stream_data2",  32'(link_tx_data),  32'hA003);
        gpp_trf_cp = 1'b0;
        tick();
        chk("stream_empty",  32'(link_tx_valid), 32'd0);
        chk("stream_cnt_end", 32'(tx_count),     32'd0);

        // TX overflow: nine pushes into eight entries while the link stalls
        link_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            gpp_tx_data = 16'hB000 + 16'(i);
            gpp_trf_cp = 1'b1;
            tick();
            if (i == 7) begin
                chk("ovf_full_at8", 32'(tx_full), 32'd1);
            end
        end
        gpp_trf_cp = 1'b0;
        chk("ovf_flag",  32'(tx_overflow),  32'd1);
        chk("ovf_count", 32'(tx_count),     32'd8);
        chk("ovf_hold",  32'(link_tx_data), 32'hB000);
        link_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("ovf_drain", 32'(link_tx_data), 32'hB000 + 32'(i));
            tick();
        end
        link_tx_ready = 1'b0;
        chk("ovf_drained", 32'(link_tx_valid), 32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ovf_clr", 32'(tx_overflow), 32'd0);

        // RX path with GPP pops
        link_rx_valid = 1'b1;
        link_rx_data = 16'h55AA;
        tick();
        link_rx_data = 16'h1234;
        tick();
        link_rx_valid = 1'b0;
        chk("rx_flag",  32'(data_rx_flag),    32'd1);
        chk("rx_head0", 32'(RAM_rx_data_out), 32'h55AA);
        chk("rx_cnt2",  32'(rx_count),        32'd2);
        gpp_rtr_cp = 1'b1;
        tick();
        gpp_rtr_cp = 1'b0;
        chk("rx_head1", 32'(RAM_rx_data_out), 32'h1234);
        gpp_rtr_cp = 1'b1;
        tick();
        gpp_rtr_cp = 1'b0;
        chk("rx_flag_off", 32'(data_rx_flag), 32'd0);
        chk("rx_no_udf",   32'(rx_underflow), 32'd0);

        // RX underflow, clear, and error-over-clear priority
        gpp_rtr_cp = 1'b1;
        tick();
        gpp_rtr_cp = 1'b0;
        chk("udf_flag",  32'(rx_underflow), 32'd1);
        chk("udf_count", 32'(rx_count),     32'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("udf_clr", 32'(rx_underflow), 32'd0);
        err_clr = 1'b1;
        gpp_rtr_cp = 1'b1;
        tick();
        err_clr = 1'b0;
        gpp_rtr_cp = 1'b0;
        chk("udf_priority", 32'(rx_underflow), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // RX full: offered word is refused while the GPP pops
        link_rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            link_rx_data = 16'hC000 + 16'(i);
            tick();
        end
        chk("rxf_count", 32'(rx_count),      32'd8);
        chk("rxf_ready", 32'(link_rx_ready), 32'd0);
        link_rx_data = 16'hDEAD;
        gpp_rtr_cp = 1'b1;
        tick();
        link_rx_valid = 1'b0;
        gpp_rtr_cp = 1'b0;
        chk("rxf_cnt7",     32'(rx_count),        32'd7);
        chk("rxf_ready_up", 32'(link_rx_ready),   32'd1);
        for (int i = 1; i < 8; i++) begin
            chk("rxf_order", 32'(RAM_rx_data_out), 32'hC000 + 32'(i));
            gpp_rtr_cp = 1'b1;
            tick();
            gpp_rtr_cp = 1'b0;
        end
        chk("rxf_empty", 32'(data_rx_flag), 32'd0);

        // Asynchronous reset mid-transfer
        for (int i = 0; i < 5; i++) begin
            gpp_tx_data = 16'hE000 + 16'(i);
            gpp_trf_cp = 1'b1;
            tick();
        end
        gpp_trf_cp = 1'b0;
        chk("mid_cnt5", 32'(tx_count), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_cnt",      32'({tx_count, rx_count}), 32'd0);
        chk("arst_valid",    32'(link_tx_valid), 32'd0);
        chk("arst_rx_ready", 32'(link_rx_ready), 32'd0);
        #2;
        rst = 1'b1;
        tick();
        chk("rel_rx_ready", 32'(link_rx_ready), 32'd1);
        link_tx_ready = 1'b1;
        gpp_tx_data = 16'hF00D;
        gpp_trf_cp = 1'b1;
        tick();
        gpp_trf_cp = 1'b0;
        chk("rel_valid", 32'(link_tx_valid), 32'd1);
        chk("rel_data",  32'(link_tx_data),  32'hF00D);
        tick();
        chk("rel_drained", 32'(tx_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
